// File: rtl/dsp_pipeline_pkg.sv
// Shared DSP pipeline definitions: channel index type, default channel count
// and statistics counter width, used by producers, collector and consumers.
package dsp_pipeline_pkg;

   localparam int NUM_CHANNELS_DEF = 4;
   localparam int MAX_CHANNELS     = 8;
   localparam int STATS_W          = 16;

   // Wide enough for any channel index up to MAX_CHANNELS-1
   typedef logic [2:0] ch_idx_t;

   // Index width with a floor of one bit so single-channel builds stay legal
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/collector_fifo.sv
// Single-clock synchronous FIFO with flush, one per collector channel.
// Push when full and pop when empty are ignored; the read port is
// combinational from the head entry.
module collector_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; flush behaves like reset for contents
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/channel_collector.sv
// Collects free-running per-channel sample streams into per-channel FIFOs and
// merges them round-robin into one tagged valid/ready output stream.
// Samples arriving at a full FIFO are dropped and flagged in a sticky
// overflow bit. Optional per-channel accepted-sample counters are built when
// CHANNEL_COLLECTOR_STATS_EN is defined; otherwise sample_count reads zero.
module channel_collector
   import dsp_pipeline_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data_in,
   input  logic [NUM_CHANNELS-1:0]            ch_valid_in,
   input  logic                               flush,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic [idx_width(NUM_CHANNELS)-1:0] out_channel,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NUM_CHANNELS-1:0]            overflow,
   input  logic [NUM_CHANNELS-1:0]            overflow_clr,
   output logic [NUM_CHANNELS*STATS_W-1:0]    sample_count
);

   localparam int CW = idx_width(NUM_CHANNELS);

   logic [NUM_CHANNELS-1:0]                 fifo_full;
   logic [NUM_CHANNELS-1:0]                 fifo_empty;
   logic [NUM_CHANNELS-1:0]                 push;
   logic [NUM_CHANNELS-1:0]                 pop;
   logic [NUM_CHANNELS-1:0]                 drop;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] fifo_dout;

   ch_idx_t ptr;
   ch_idx_t grant;
   logic    found;
   logic    load;
   int      idx;

   // Fullness is taken before any same-cycle pop, so a pop never makes room.
   // Samples in a flush cycle are discarded silently.
   assign push = ch_valid_in & ~fifo_full & {NUM_CHANNELS{~flush}};
   assign drop = ch_valid_in &  fifo_full & {NUM_CHANNELS{~flush}};

   // Output register takes a new sample when empty or being consumed
   assign load = !out_valid || out_ready;
   assign pop  = (load && found && !flush) ? (NUM_CHANNELS'(1) << grant) : '0;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      collector_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (ch_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout  (fifo_dout[i]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );
   end

   // Round-robin arbiter: first non-empty FIFO at or above ptr, wrapping
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = (int'(ptr) + k) % NUM_CHANNELS;
         if (!found && !fifo_empty[idx]) begin
            found = 1'b1;
            grant = ch_idx_t'(idx);
         end
      end
   end

   // Output register and round-robin pointer; data/channel hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_channel <= '0;
         ptr         <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         if (found) begin
            out_valid   <= 1'b1;
            out_data    <= fifo_dout[grant];
            out_channel <= grant[CW-1:0];
            ptr         <= ch_idx_t'((int'(grant) + 1) % NUM_CHANNELS);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Sticky drop flags; a new drop in the clear cycle keeps the flag set
   always_ff @(posedge clk) begin
      if (rst) overflow <= '0;
      else     overflow <= (overflow & ~overflow_clr) | drop;
   end

`ifdef CHANNEL_COLLECTOR_STATS_EN
   logic [NUM_CHANNELS-1:0][STATS_W-1:0] cnt;

   // Accepted-push counters, wrapping, untouched by flush
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++)
            if (push[i]) cnt[i] <= cnt[i] + 1'b1;
      end
   end

   assign sample_count = cnt;
`else
   assign sample_count = '0;
`endif

endmodule

// File: tb/tb_channel_collector.sv
// Directed self-checking bench for channel_collector (4 channels, depth 4).
module tb_channel_collector;

   localparam int DW = 32;
   localparam int NC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC*DW-1:0] ch_data_in;
   logic [NC-1:0]   ch_valid_in;
   logic            flush;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_channel;
   logic            out_valid;
   logic            out_ready;
   logic [NC-1:0]   overflow;
   logic [NC-1:0]   overflow_clr;
   logic [NC*16-1:0] sample_count;

   int n_chk = 0;
   int n_err = 0;
   logic [DW-1:0] got[$];

   channel_collector #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_data_in   (ch_data_in),
      .ch_valid_in  (ch_valid_in),
      .flush        (flush),
      .out_data     (out_data),
      .out_channel  (out_channel),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   // Record every accepted output transfer
   always @(posedge clk)
      if (!rst && out_valid && out_ready) got.push_back(out_data);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [DW-1:0] d);
      ch_data_in[c*DW +: DW] = d;
      ch_valid_in[c] = 1'b1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_data"}, 64'(out_data), 64'd0);
      chk({tag, "_chan"}, 64'(out_channel), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), 64'd0);
      chk({tag, "_cnt"}, 64'(sample_count), 64'd0);
   endtask

   logic [63:0] cnt_exp;
   logic        pv, pr;
   logic [DW-1:0] pd;
   logic [1:0]  pc;

   initial begin
      rst = 1'b1; ch_data_in = '0; ch_valid_in = '0; flush = 1'b0;
      out_ready = 1'b0; overflow_clr = '0;
      tick(); tick();
      rst = 1'b0;
      chk_reset_state("reset");

      // Single sample latency
      out_ready = 1'b1;
      set_ch(0, 32'h123);
      tick();
      ch_valid_in = '0;
      chk("single_lat0", 64'(out_valid), 64'd0);
      tick();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_data", 64'(out_data), 64'h123);
      chk("single_chan", 64'(out_channel), 64'd0);
      tick();
      chk("single_idle", 64'(out_valid), 64'd0);
      chk("single_hold", 64'(out_data), 64'h123);

      // Round robin from pointer 0
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < NC; c++) set_ch(c, 32'(10 + c));
      tick();
      ch_valid_in = '0;
      for (int c = 0; c < NC; c++) begin
         tick();
         chk("rr_valid", 64'(out_valid), 64'd1);
         chk("rr_chan", 64'(out_channel), 64'(c));
         chk("rr_data", 64'(out_data), 64'(10 + c));
      end
      tick();
      chk("rr_idle", 64'(out_valid), 64'd0);

      // Overflow on channel 2 with output stalled
      out_ready = 1'b0;
      for (int s = 1; s <= 6; s++) begin
         set_ch(2, 32'(s));
         tick();
      end
      ch_valid_in = '0;
      chk("ovf_flag", 64'(overflow), 64'b0100);
      chk("ovf_outv", 64'(out_valid), 64'd1);
      chk("ovf_outd", 64'(out_data), 64'd1);
      chk("ovf_outc", 64'(out_channel), 64'd2);
      overflow_clr = 4'b0100;
      tick();
      overflow_clr = '0;
      chk("ovf_clr", 64'(overflow), 64'd0);
      chk("ovf_hold", 64'(out_data), 64'd1);
      out_ready = 1'b1;
      for (int s = 1; s <= 5; s++) begin
         chk("ovf_drain_v", 64'(out_valid), 64'd1);
         chk("ovf_drain_d", 64'(out_data), 64'(s));
         tick();
      end
      chk("ovf_drain_end", 64'(out_valid), 64'd0);

      // Backpressure: ready toggles while channel 1 streams
      got.delete();
      for (int i = 0; i < 18; i++) begin
         ch_valid_in = '0;
         if (i % 2 == 0 && i < 16) set_ch(1, 32'h100 + 32'(i / 2));
         out_ready = (i % 2) != 0;
         pv = out_valid; pr = out_ready; pd = out_data; pc = out_channel;
         tick();
         if (pv && !pr) begin
            chk("bp_hold_d", 64'(out_data), 64'(pd));
            chk("bp_hold_c", 64'(out_channel), 64'(pc));
         end
      end
      ch_valid_in = '0;
      out_ready = 1'b1;
      repeat (6) tick();
      chk("bp_count", 64'(got.size()), 64'd8);
      for (int j = 0; j < 8; j++)
         chk("bp_order", 64'(j < got.size() ? got[j] : 32'hdead), 64'(32'h100 + 32'(j)));
      chk("bp_noovf", 64'(overflow), 64'd0);

      // Flush with three buffered samples
      out_ready = 1'b0;
      set_ch(0, 32'h55); set_ch(1, 32'h66); set_ch(3, 32'h77);
      tick();
      ch_valid_in = '0;
      tick();
      chk("fl_pre_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      set_ch(2, 32'h99);
      tick();
      flush = 1'b0;
      ch_valid_in = '0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_noovf", 64'(overflow), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_empty", 64'(out_valid), 64'd0);
      end
`ifdef CHANNEL_COLLECTOR_STATS_EN
      cnt_exp = {16'd2, 16'd6, 16'd10, 16'd2};
`else
      cnt_exp = 64'd0;
`endif
      chk("fl_cnt", 64'(sample_count), cnt_exp);

      // Reset mid-stream with overflow pending
      out_ready = 1'b0;
      for (int s = 0; s < 6; s++) begin
         set_ch(0, 32'(s + 40));
         set_ch(3, 32'(s + 80));
         tick();
      end
      ch_valid_in = '0;
      chk("rs_pre_ovf", 64'(overflow), 64'b1001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_state("midrst");
      out_ready = 1'b1;
      tick(); tick();
      chk("rs_after", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/channel_collector.md
# channel_collector

Sink end of the per-channel sample streams in the DSP pipeline. Accepts the free-running `data_out`/`valid_out` pairs of up to NUM_CHANNELS channel processors, which have no backpressure, and buffers each channel in its own small FIFO. It merges the channels round-robin into one tagged output stream with a valid/ready handshake toward the downstream mixer/DMA. Lost samples are flagged per channel rather than stalling upstream.

## Interface
Parameters:
- DATA_WIDTH, 32, sample width; matches channel processor output
- NUM_CHANNELS, 4, number of upstream channels, 1..8
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2

Ports:
- clk  input  1  single clock for all logic
- rst  input  1  synchronous, active-high reset
- ch_data_in  input  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_valid_in  input  NUM_CHANNELS  per-channel sample strobe, one sample per high cycle
- flush  input  1  discard all buffered and output samples
- out_data  output  DATA_WIDTH  merged sample
- out_channel  output  $clog2(NUM_CHANNELS) (min 1)  source channel index of out_data
- out_valid  output  1  out_data/out_channel valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- overflow  output  NUM_CHANNELS  sticky per-channel sample-drop flag
- overflow_clr  input  NUM_CHANNELS  per-bit clear of overflow
- sample_count  output  NUM_CHANNELS*16  per-channel accepted-sample counters; see Configuration

## Operation
- Reset (rst high at a clk edge): all FIFOs empty, output register empty. out_valid=0, out_data=0, out_channel=0, overflow=0, sample_count=0. The round-robin pointer points at channel 0. Reset mid-transfer discards everything with no partial state kept.
- Push: ch_valid_in[i] writes into FIFO i if FIFO i holds fewer than FIFO_DEPTH entries, measured before any same-cycle pop. If FIFO i is full, the sample is dropped and overflow[i] is set. A pop in the same cycle does not make room for that sample.
- overflow[i]: sticky. overflow_clr[i] clears it. If a clear and a new drop happen in the same cycle, set wins.
- Output load: the output register loads when it is empty or being consumed (out_valid && out_ready).
  - Arbiter picks the first non-empty FIFO, searching from the pointer upward with wrap-around.
  - That FIFO is popped, and the pointer moves to granted+1 (mod NUM_CHANNELS).
  - If all FIFOs are empty, out_valid drops to 0 and out_data/out_channel hold their last values.
- Hold: while out_valid && !out_ready, out_data and out_channel stay stable. No pop occurs.
- Flush: at the clocked edge it empties all FIFOs and clears out_valid. The pointer, overflow and sample_count are unchanged. ch_valid_in in the flush cycle is discarded without setting overflow.
- Per-channel ordering is preserved. Cross-channel order follows the round-robin rule only.

## Timing
- Latency: a sample pushed at edge k into an empty pipeline with a free output register appears with out_valid=1 after edge k+1 (2 cycles).
- Throughput: one output sample per cycle while out_ready=1 and any FIFO is non-empty.
- Fairness: each channel is served within NUM_CHANNELS consecutive output transfers when backlogged.
- All outputs are registered. The only combinational path is arbiter → output register; no path from out_ready to out_valid exists.

## Configuration
- CHANNEL_COLLECTOR_STATS_EN defined: one 16-bit counter per channel increments on every accepted push. It wraps at 0xFFFF→0, is not cleared by flush, and is cleared by rst.
- Not defined: counters are not built; sample_count is tied to 0.

## Structure
- Shared package dsp_pipeline_pkg: channel index type, NUM_CHANNELS default constant and the STATS counter width (16). Upstream channel processors and downstream consumers use the same package.
- Sub-module collector_fifo: single-clock synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with push/pop/full/empty and a flush input, instantiated once per channel. The arbiter and output register stay in channel_collector.

## Test plan
- Single sample: ch_valid_in=0001, ch0 data 0x00000123 at edge k, out_ready=1 → out_valid=1 after edge k+1 with out_data=0x123 and out_channel=0, then out_valid=0.
- Round-robin: all 4 channels push 10+i for one cycle, out_ready=1 → outputs on 4 consecutive cycles in order ch0,1,2,3 with data 10,11,12,13.
- Overflow: out_ready=0, ch2 pushes 6 samples (FIFO_DEPTH=4) → 1 sample sits in the output register, FIFO holds 4, the 6th is dropped and overflow[2]=1. A clear via overflow_clr[2] zeroes the flag. Draining returns samples 1–5 in order.
- Backpressure hold: out_ready toggles 0/1 every cycle while ch1 streams → out_data is stable during every ready=0 cycle, with no loss or duplication.
- Flush and reset: with 3 buffered samples, pulsing flush gives out_valid=0 next cycle and nothing further is output. With STATS enabled, sample_count is unchanged by flush. rst mid-stream returns all outputs to reset values.
